// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with two write ports, hardwired-zero r0 and a pending scoreboard; define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports
module regfile_mp #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int NRD   = 2,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NRD*AW-1:0]    ra_i,
    output logic [NRD*WIDTH-1:0] rd_o,
    output logic [NRD-1:0]       rbusy_o,
    input  logic                 we0_i,
    input  logic [AW-1:0]        wa0_i,
    input  logic [WIDTH-1:0]     wd0_i,
    input  logic                 we1_i,
    input  logic [AW-1:0]        wa1_i,
    input  logic [WIDTH-1:0]     wd1_i,
    input  logic                 bset_i,
    input  logic [AW-1:0]        bsa_i,
    output logic                 conflict_o,
    output logic [AW:0]          pend_cnt_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0] busy_q, busy_d;
    logic             conflict_q, conflict_d;
    logic [AW:0]      pend_cnt_q, pend_cnt_d;
    logic             wr0, wr1, set;

    assign wr0 = we0_i && wa0_i != '0;
    assign wr1 = we1_i && wa1_i != '0;
    assign set = bset_i && bsa_i != '0;
    assign conflict_d = wr0 && wr1 && wa0_i == wa1_i;
    assign conflict_o = conflict_q;
    assign pend_cnt_o = pend_cnt_q;

    // next register contents and pending bits: port 1 beats port 0, a pending mark beats a clearing write
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i]  = (wr1 && wa1_i == AW'(i)) ? wd1_i :
                        (wr0 && wa0_i == AW'(i)) ? wd0_i : mem_q[i];
            busy_d[i] = (set && bsa_i == AW'(i)) ? 1'b1 :
                        ((wr0 && wa0_i == AW'(i)) || (wr1 && wa1_i == AW'(i))) ? 1'b0 : busy_q[i];
        end
    end

    // pending count tracks the busy vector that the next edge will load
    always_comb begin
        pend_cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) pend_cnt_d = pend_cnt_d + (AW+1)'(busy_d[i]);
    end

    // state update; r0 is never written so it stays at its reset value of zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q      <= '{default: '0};
            busy_q     <= '0;
            conflict_q <= 1'b0;
            pend_cnt_q <= '0;
        end else begin
            mem_q      <= mem_d;
            busy_q     <= busy_d;
            conflict_q <= conflict_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] a;
        assign a = ra_i[k*AW +: AW];
`ifdef REGFILE_BYPASS_EN
        logic hit0, hit1;
        assign hit0 = rst_n && wr0 && wa0_i == a;
        assign hit1 = rst_n && wr1 && wa1_i == a;
        assign rd_o[k*WIDTH +: WIDTH] = hit1 ? wd1_i : hit0 ? wd0_i : mem_q[a];
        assign rbusy_o[k] = (hit0 || hit1) ? (rst_n && set && bsa_i == a) : busy_q[a];
`else
        assign rd_o[k*WIDTH +: WIDTH] = mem_q[a];
        assign rbusy_o[k] = busy_q[a];
`endif
    end
endmodule
